// File: rtl/vga_display_controller.sv
// VGA display controller: free-running raster timing, linear frame-store
// read addressing, a latency-matched pixel pipeline and tear-free double
// buffer bank swapping at the start of vertical blanking.
module vga_display_controller #(
  parameter int          READ_LATENCY = 2,
  parameter int          H_VISIBLE    = 800,
  parameter int          H_FP         = 40,
  parameter int          H_SYNC       = 128,
  parameter int          H_BP         = 88,
  parameter int          V_VISIBLE    = 600,
  parameter int          V_FP         = 1,
  parameter int          V_SYNC       = 4,
  parameter int          V_BP         = 23,
  parameter int          IMG_WIDTH    = 720,
  parameter int          IMG_HEIGHT   = 480,
  parameter int          IMG_X0       = 40,
  parameter int          IMG_Y0       = 60,
  parameter logic [23:0] BORDER_RGB   = 24'h000000
) (
  input  logic        internal_clock_40,
  input  logic        resetn,
  input  logic        Swap_Request_I,
  output logic [18:0] Video_Address_O,
  input  logic [31:0] Video_Data_I,
  output logic        Bank_Select_O,
  output logic        Frame_Swap_O,
  output logic [7:0]  VGA_Red_O,
  output logic [7:0]  VGA_Green_O,
  output logic [7:0]  VGA_Blue_O,
  output logic        VGA_HSync_O,
  output logic        VGA_VSync_O,
  output logic        VGA_Blank_O
);

  localparam int H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;
  localparam int HCW     = (H_TOTAL > 1) ? $clog2(H_TOTAL) : 1;
  localparam int VCW     = (V_TOTAL > 1) ? $clog2(V_TOTAL) : 1;

  localparam logic [HCW-1:0] H_LAST       = HCW'(H_TOTAL - 1);
  localparam logic [HCW-1:0] H_VIS_END    = HCW'(H_VISIBLE);
  localparam logic [HCW-1:0] H_SYNC_START = HCW'(H_VISIBLE + H_FP);
  localparam logic [HCW-1:0] H_SYNC_END   = HCW'(H_VISIBLE + H_FP + H_SYNC);
  localparam logic [HCW-1:0] IMG_X_START  = HCW'(IMG_X0);
  localparam logic [HCW-1:0] IMG_X_END    = HCW'(IMG_X0 + IMG_WIDTH);

  localparam logic [VCW-1:0] V_LAST       = VCW'(V_TOTAL - 1);
  localparam logic [VCW-1:0] V_VIS_END    = VCW'(V_VISIBLE);
  localparam logic [VCW-1:0] V_SYNC_START = VCW'(V_VISIBLE + V_FP);
  localparam logic [VCW-1:0] V_SYNC_END   = VCW'(V_VISIBLE + V_FP + V_SYNC);
  localparam logic [VCW-1:0] IMG_Y_START  = VCW'(IMG_Y0);
  localparam logic [VCW-1:0] IMG_Y_END    = VCW'(IMG_Y0 + IMG_HEIGHT);

  // Per-position raster flags carried down the latency-matching pipeline
  typedef struct packed {
    logic vis;
    logic hs;
    logic vs;
    logic img;
  } flags_t;

  logic [HCW-1:0] h_q, h_d;
  logic [VCW-1:0] v_q, v_d;
  logic [18:0]    ptr_q, ptr_d;
  logic [18:0]    addr_q, addr_d;
  flags_t         pipe_q [READ_LATENCY+1];
  flags_t         pipe_d [READ_LATENCY+1];
  logic [23:0]    rgb_q, rgb_d;
  logic           hsync_q, hsync_d;
  logic           vsync_q, vsync_d;
  logic           blank_q, blank_d;
  logic           pending_q, pending_d;
  logic           bank_q, bank_d;
  logic           swap_q, swap_d;

  flags_t cur_flags;
  logic   frame_end;
  logic   vblank_start;
  logic   data_unused;

  assign data_unused = ^Video_Data_I[31:24];

  // Raster position decode for the position the counters hold this cycle
  always_comb begin
    cur_flags     = '0;
    cur_flags.vis = (h_q < H_VIS_END) && (v_q < V_VIS_END);
    cur_flags.hs  = (h_q >= H_SYNC_START) && (h_q < H_SYNC_END);
    cur_flags.vs  = (v_q >= V_SYNC_START) && (v_q < V_SYNC_END);
    cur_flags.img = cur_flags.vis &&
                    (h_q >= IMG_X_START) && (h_q < IMG_X_END) &&
                    (v_q >= IMG_Y_START) && (v_q < IMG_Y_END);
    frame_end     = (h_q == H_LAST) && (v_q == V_LAST);
    vblank_start  = (h_q == '0) && (v_q == V_VIS_END);
  end

  // Counter advance and linear read-address generation (pointer walks the image in raster order)
  always_comb begin
    h_d    = h_q;
    v_d    = v_q;
    ptr_d  = ptr_q;
    addr_d = addr_q;
    if (h_q == H_LAST) begin
      h_d = '0;
      v_d = (v_q == V_LAST) ? '0 : v_q + VCW'(1);
    end else begin
      h_d = h_q + HCW'(1);
    end
    if (cur_flags.img) begin
      addr_d = ptr_q;
      ptr_d  = ptr_q + 19'd1;
    end
    if (frame_end) begin
      ptr_d = '0;
    end
  end

  // Delay line so sync/blank/colour decisions line up with the returned pixel data
  always_comb begin
    pipe_d[0] = cur_flags;
    for (int i = 1; i <= READ_LATENCY; i++) begin
      pipe_d[i] = pipe_q[i-1];
    end
    hsync_d = pipe_q[READ_LATENCY].hs;
    vsync_d = pipe_q[READ_LATENCY].vs;
    blank_d = !pipe_q[READ_LATENCY].vis;
    if (pipe_q[READ_LATENCY].img) begin
      rgb_d = Video_Data_I[23:0];
    end else if (pipe_q[READ_LATENCY].vis) begin
      rgb_d = BORDER_RGB;
    end else begin
      rgb_d = 24'h000000;
    end
  end

  // Bank swap only in the vblank-start cycle; a request in that same cycle is honoured at once
  always_comb begin
    bank_d    = bank_q;
    swap_d    = 1'b0;
    pending_d = pending_q | Swap_Request_I;
    if (vblank_start && (pending_q || Swap_Request_I)) begin
      bank_d    = ~bank_q;
      swap_d    = 1'b1;
      pending_d = 1'b0;
    end
  end

  // All state, cleared asynchronously so a reset mid-line aborts the frame and drops any pending swap
  always_ff @(posedge internal_clock_40 or negedge resetn) begin
    if (!resetn) begin
      h_q       <= '0;
      v_q       <= '0;
      ptr_q     <= '0;
      addr_q    <= '0;
      for (int i = 0; i <= READ_LATENCY; i++) begin
        pipe_q[i] <= '0;
      end
      rgb_q     <= '0;
      hsync_q   <= 1'b0;
      vsync_q   <= 1'b0;
      blank_q   <= 1'b1;
      pending_q <= 1'b0;
      bank_q    <= 1'b0;
      swap_q    <= 1'b0;
    end else begin
      h_q       <= h_d;
      v_q       <= v_d;
      ptr_q     <= ptr_d;
      addr_q    <= addr_d;
      for (int i = 0; i <= READ_LATENCY; i++) begin
        pipe_q[i] <= pipe_d[i];
      end
      rgb_q     <= rgb_d;
      hsync_q   <= hsync_d;
      vsync_q   <= vsync_d;
      blank_q   <= blank_d;
      pending_q <= pending_d;
      bank_q    <= bank_d;
      swap_q    <= swap_d;
    end
  end

  assign Video_Address_O = addr_q;
  assign Bank_Select_O   = bank_q;
  assign Frame_Swap_O    = swap_q;
  assign VGA_Red_O       = rgb_q[23:16];
  assign VGA_Green_O     = rgb_q[15:8];
  assign VGA_Blue_O      = rgb_q[7:0];
  assign VGA_HSync_O     = hsync_q;
  assign VGA_VSync_O     = vsync_q;
  assign VGA_Blank_O     = blank_q;

endmodule

// File: tb/tb_vga_display_controller.sv
// Self-checking bench for vga_display_controller using a shrunken raster
// (29 clocks x 17 lines) so several frames fit in a short run.
module tb_vga_display_controller;

  localparam int L      = 2;
  localparam int HV     = 20;
  localparam int HFP    = 2;
  localparam int HS     = 4;
  localparam int HBP    = 3;
  localparam int VV     = 12;
  localparam int VFP    = 1;
  localparam int VS     = 2;
  localparam int VBP    = 2;
  localparam int W      = 12;
  localparam int H      = 8;
  localparam int X0     = 3;
  localparam int Y0     = 2;
  localparam logic [23:0] BORDER = 24'hA5C33C;
  localparam int HT     = HV + HFP + HS + HBP;
  localparam int VT     = VV + VFP + VS + VBP;
  localparam int FRAME  = HT * VT;

  logic        clk;
  logic        resetn;
  logic        swap_req;
  logic [18:0] video_addr;
  logic [31:0] video_data;
  logic        bank_sel;
  logic        frame_swap;
  logic [7:0]  red, green, blue;
  logic        hsync, vsync, blank;

  int checks = 0;
  int errors = 0;

  vga_display_controller #(
    .READ_LATENCY(L), .H_VISIBLE(HV), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
    .V_VISIBLE(VV), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP),
    .IMG_WIDTH(W), .IMG_HEIGHT(H), .IMG_X0(X0), .IMG_Y0(Y0),
    .BORDER_RGB(BORDER)
  ) dut (
    .internal_clock_40(clk),
    .resetn(resetn),
    .Swap_Request_I(swap_req),
    .Video_Address_O(video_addr),
    .Video_Data_I(video_data),
    .Bank_Select_O(bank_sel),
    .Frame_Swap_O(frame_swap),
    .VGA_Red_O(red),
    .VGA_Green_O(green),
    .VGA_Blue_O(blue),
    .VGA_HSync_O(hsync),
    .VGA_VSync_O(vsync),
    .VGA_Blank_O(blank)
  );

  // 10 ns pixel clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Frame store model: data equals address, two cycles after the address
  logic [18:0] mem_pipe [0:1];
  initial begin
    mem_pipe[0] = '0;
    mem_pipe[1] = '0;
  end
  always @(posedge clk) begin
    mem_pipe[0] <= video_addr;
    mem_pipe[1] <= mem_pipe[0];
  end
  assign video_data = {8'h5A, 5'b0, mem_pipe[1]};

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit inImg(input int hh, input int vv);
    return (hh < HV) && (vv < VV) && (hh >= X0) && (hh < X0 + W) &&
           (vv >= Y0) && (vv < Y0 + H);
  endfunction

  // Reference model state, indexed by cycle k since reset release
  int          k = 0;
  logic [18:0] exp_addr = '0;
  logic        exp_bank = 1'b0;
  logic        exp_swap = 1'b0;
  logic        exp_pend = 1'b0;
  int          swap_count = 0;
  int          last_swap_pos = -1;
  logic        hs_prev = 1'b0, vs_prev = 1'b0;
  int          hs_rise = -1, vs_rise = -1;
  int          blank_low = 0;

  // Compare DUT outputs with the model on every falling edge
  always @(negedge clk) begin
    if (!resetn) begin
      checkOutput("rst_addr", {13'b0, video_addr}, 32'h0);
      checkOutput("rst_bank", {31'b0, bank_sel}, 32'h0);
      checkOutput("rst_swap", {31'b0, frame_swap}, 32'h0);
      checkOutput("rst_rgb", {8'b0, red, green, blue}, 32'h0);
      checkOutput("rst_sync", {30'b0, hsync, vsync}, 32'h0);
      checkOutput("rst_blank", {31'b0, blank}, 32'h1);
      k = 0;
      exp_addr = '0;
      exp_bank = 1'b0;
      exp_swap = 1'b0;
      exp_pend = 1'b0;
      hs_prev = 1'b0;
      vs_prev = 1'b0;
      hs_rise = -1;
      vs_rise = -1;
      blank_low = 0;
    end else begin
      int q, fp, hq, vq, p, hp, vp;
      logic [23:0] e_rgb;
      logic e_hs, e_vs, e_blank;
      q = k - (L + 2);
      e_rgb = 24'h0; e_hs = 1'b0; e_vs = 1'b0; e_blank = 1'b1;
      hq = -1; vq = -1;
      if (q >= 0) begin
        fp = q % FRAME;
        hq = fp % HT;
        vq = fp / HT;
        e_hs = (hq >= HV + HFP) && (hq < HV + HFP + HS);
        e_vs = (vq >= VV + VFP) && (vq < VV + VFP + VS);
        e_blank = !((hq < HV) && (vq < VV));
        if (inImg(hq, vq)) e_rgb = 24'((vq - Y0) * W + (hq - X0));
        else if (!e_blank) e_rgb = BORDER;
      end
      checkOutput("addr", {13'b0, video_addr}, {13'b0, exp_addr});
      checkOutput("bank", {31'b0, bank_sel}, {31'b0, exp_bank});
      checkOutput("frame_swap", {31'b0, frame_swap}, {31'b0, exp_swap});
      checkOutput("rgb", {8'b0, red, green, blue}, {8'b0, e_rgb});
      checkOutput("hsync", {31'b0, hsync}, {31'b0, e_hs});
      checkOutput("vsync", {31'b0, vsync}, {31'b0, e_vs});
      checkOutput("blank", {31'b0, blank}, {31'b0, e_blank});

      // Hand-computed pixels pinning the model
      if (hq == 3 && vq == 2) checkOutput("img_first_px", {8'b0, red, green, blue}, 32'h0);
      if (hq == 4 && vq == 2) checkOutput("img_second_px", {8'b0, red, green, blue}, 32'h1);
      if (hq == 14 && vq == 9) checkOutput("img_last_px", {8'b0, red, green, blue}, 32'h5F);
      if (hq == 5 && vq == 1) begin
        checkOutput("border_rgb", {8'b0, red, green, blue}, 32'hA5C33C);
        checkOutput("border_blank", {31'b0, blank}, 32'h0);
      end
      if (hq == 25 && vq == 1) begin
        checkOutput("hblank_rgb", {8'b0, red, green, blue}, 32'h0);
        checkOutput("hblank_blank", {31'b0, blank}, 32'h1);
      end
      if (k - 1 == 61 || k - 1 == FRAME + 61)
        checkOutput("addr_frame_start", {13'b0, video_addr}, 32'h0);
      if (k - 1 == FRAME + 62)
        checkOutput("addr_frame_second", {13'b0, video_addr}, 32'h1);

      // Sync period / width and visible-pixel count per frame
      if (!blank) blank_low++;
      if (hsync && !hs_prev) begin
        if (hs_rise >= 0) checkOutput("hs_period", k - hs_rise, 29);
        hs_rise = k;
      end
      if (!hsync && hs_prev && hs_rise >= 0) checkOutput("hs_width", k - hs_rise, 4);
      if (vsync && !vs_prev) begin
        if (vs_rise >= 0) begin
          checkOutput("vs_period", k - vs_rise, 493);
          checkOutput("blank_low_count", blank_low, 240);
        end
        vs_rise = k;
        blank_low = 0;
      end
      if (!vsync && vs_prev && vs_rise >= 0) checkOutput("vs_width", k - vs_rise, 58);
      hs_prev = hsync;
      vs_prev = vsync;

      if (frame_swap === 1'b1) begin
        swap_count++;
        last_swap_pos = k % FRAME;
      end

      // Advance the model across the coming clock edge
      p  = k % FRAME;
      hp = p % HT;
      vp = p / HT;
      if (inImg(hp, vp)) exp_addr = 19'((vp - Y0) * W + (hp - X0));
      if (hp == 0 && vp == VV && (exp_pend || swap_req)) begin
        exp_bank = ~exp_bank;
        exp_swap = 1'b1;
        exp_pend = 1'b0;
      end else begin
        exp_swap = 1'b0;
        exp_pend = exp_pend | swap_req;
      end
      k++;
    end
  end

  int cur = 0;

  task automatic goToCycle(input int c);
    if (c > cur) begin
      repeat (c - cur) @(posedge clk);
      #1;
      cur = c;
    end
  endtask

  // One-cycle swap request held during cycle c
  task automatic applyStimulus(input int c);
    goToCycle(c);
    swap_req = 1'b1;
    goToCycle(c + 1);
    swap_req = 1'b0;
  endtask

  initial begin
    resetn   = 1'b0;
    swap_req = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    resetn = 1'b1;
    cur    = 0;

    // Single request mid-frame swaps at vblank start
    applyStimulus(4 * HT + 5);
    goToCycle(FRAME + 10);
    checkOutput("swap_count_single", swap_count, 1);
    checkOutput("swap_pos_single", last_swap_pos, 349);
    checkOutput("bank_after_single", {31'b0, bank_sel}, 32'h1);

    // Three requests in one frame give one swap
    applyStimulus(FRAME + 2 * HT);
    applyStimulus(FRAME + 5 * HT);
    applyStimulus(FRAME + 8 * HT);
    goToCycle(2 * FRAME + 10);
    checkOutput("swap_count_triple", swap_count, 2);
    checkOutput("bank_after_triple", {31'b0, bank_sel}, 32'h0);

    // Request exactly at vblank start is taken immediately
    applyStimulus(2 * FRAME + 348);
    goToCycle(3 * FRAME + 10);
    checkOutput("swap_count_same_cycle", swap_count, 3);
    checkOutput("swap_pos_same_cycle", last_swap_pos, 349);

    // Request one cycle late waits for the following frame
    applyStimulus(3 * FRAME + 349);
    goToCycle(4 * FRAME + 5);
    checkOutput("swap_count_late_wait", swap_count, 3);
    goToCycle(4 * FRAME + 400);
    checkOutput("swap_count_late_done", swap_count, 4);
    checkOutput("swap_pos_late", last_swap_pos, 349);

    // Reset mid-frame with a swap pending discards it
    applyStimulus(5 * FRAME + 3 * HT);
    goToCycle(5 * FRAME + 6 * HT + 7);
    resetn = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_midframe_bank", {31'b0, bank_sel}, 32'h0);
    resetn = 1'b1;
    cur    = 0;
    goToCycle(FRAME + 20);
    checkOutput("swap_count_after_reset", swap_count, 4);
    checkOutput("bank_after_reset", {31'b0, bank_sel}, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
